// File: rtl/load_store_unit.sv
// load_store_unit: memory stage with req/ack handshake, store strobes, load alignment and timeout (optional LSU_MISALIGN_TRAP_EN)
module load_store_unit #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_value_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_wstrb_out,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ack_in,
  output logic        done_out,
  output logic        wb_en_out,
  output logic [4:0]  wb_rd_out,
  output logic [31:0] wb_data_out,
  output logic        fault_out,
  output logic        misalign_out
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(ACK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] lo_q, lo_d;
  logic req_d, we_d, done_d, wb_en_d, fault_d, mis_d;
  logic [31:0] addr_d, wdata_d, wb_data_d, ld_val, rsh;
  logic [3:0] wstrb_d;
  logic [4:0] wb_rd_d;
  logic accept, is_load, is_store, is_alu, legal, trap;
  logic [1:0] size, eff_lo;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  assign ready_out = state == IDLE;
  assign accept    = valid_in & ready_out;
  assign is_load   = opcode_in == OP_LOAD;
  assign is_store  = opcode_in == OP_STORE;
  assign is_alu    = opcode_in == OP_REG || opcode_in == OP_IMM;
  assign size      = funct3_in[1:0];
  assign legal     = is_load ? (funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             : (funct3_in inside {3'b000, 3'b001, 3'b010});
  assign eff_lo    = size == 2'b01 ? {alu_result_in[1], 1'b0} :
                     size == 2'b10 ? 2'b00 : alu_result_in[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (size == 2'b01 && alu_result_in[0]) || (size == 2'b10 && alu_result_in[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif
  // Select and extend the addressed lane of the returned read word
  always_comb begin
    rsh    = mem_rdata_in >> {lo_q, 3'b000};
    lane_b = rsh[7:0];
    lane_h = lo_q[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    ld_val = f3_q == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
             f3_q == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
             f3_q == 3'b100 ? {24'b0, lane_b} :
             f3_q == 3'b101 ? {16'b0, lane_h} : mem_rdata_in;
  end
  // Next-state and next-output logic; registered outputs hold unless updated
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    f3_d      = f3_q;
    lo_d      = lo_q;
    req_d     = mem_req_out;
    we_d      = mem_we_out;
    addr_d    = mem_addr_out;
    wdata_d   = mem_wdata_out;
    wstrb_d   = mem_wstrb_out;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    fault_d   = 1'b0;
    mis_d     = 1'b0;
    wb_rd_d   = wb_rd_out;
    wb_data_d = wb_data_out;
    case (state)
      IDLE: if (accept) begin
        wb_rd_d = rd_in;
        if ((is_load || is_store) && !legal) begin
          state_d = DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else if ((is_load || is_store) && trap) begin
          state_d = DONE;
          done_d  = 1'b1;
          mis_d   = 1'b1;
        end else if (is_load || is_store) begin
          state_d = ACCESS;
          cnt_d   = '0;
          f3_d    = funct3_in;
          lo_d    = eff_lo;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {alu_result_in[31:2], 2'b00};
          wdata_d = !is_store ? 32'b0 :
                    size == 2'b00 ? {4{rs2_value_in[7:0]}} :
                    size == 2'b01 ? {2{rs2_value_in[15:0]}} : rs2_value_in;
          wstrb_d = !is_store ? 4'b0000 :
                    size == 2'b00 ? 4'b0001 << eff_lo :
                    size == 2'b01 ? 4'b0011 << eff_lo : 4'b1111;
        end else begin
          state_d   = DONE;
          done_d    = 1'b1;
          wb_en_d   = is_alu;
          wb_data_d = is_alu ? alu_result_in : wb_data_out;
        end
      end
      ACCESS: if (mem_ack_in) begin
        state_d   = DONE;
        req_d     = 1'b0;
        done_d    = 1'b1;
        wb_en_d   = !mem_we_out;
        wb_data_d = mem_we_out ? wb_data_out : ld_val;
      end else if (ACK_TIMEOUT != 0 && cnt + 1'b1 == TIMEOUT) begin
        state_d = DONE;
        req_d   = 1'b0;
        done_d  = 1'b1;
        fault_d = 1'b1;
      end else begin
        cnt_d = cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      lo_q          <= '0;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_wstrb_out <= '0;
      done_out      <= 1'b0;
      wb_en_out     <= 1'b0;
      wb_rd_out     <= '0;
      wb_data_out   <= '0;
      fault_out     <= 1'b0;
      misalign_out  <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      f3_q          <= f3_d;
      lo_q          <= lo_d;
      mem_req_out   <= req_d;
      mem_we_out    <= we_d;
      mem_addr_out  <= addr_d;
      mem_wdata_out <= wdata_d;
      mem_wstrb_out <= wstrb_d;
      done_out      <= done_d;
      wb_en_out     <= wb_en_d;
      wb_rd_out     <= wb_rd_d;
      wb_data_out   <= wb_data_d;
      fault_out     <= fault_d;
      misalign_out  <= mis_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
  logic clk_in = 1'b0, reset_in = 1'b1, valid_in = 1'b0, mem_ack_in = 1'b0;
  logic [6:0] opcode_in = '0;
  logic [2:0] funct3_in = '0;
  logic [4:0] rd_in = '0;
  logic [31:0] alu_result_in = '0, rs2_value_in = '0, mem_rdata_in = '0;
  logic ready_out, mem_req_out, mem_we_out, done_out, wb_en_out, fault_out, misalign_out;
  logic [31:0] mem_addr_out, mem_wdata_out, wb_data_out;
  logic [3:0] mem_wstrb_out;
  logic [4:0] wb_rd_out;
  int total = 0, bad = 0;

  load_store_unit #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .valid_in(valid_in), .ready_out(ready_out),
    .opcode_in(opcode_in), .funct3_in(funct3_in), .rd_in(rd_in),
    .alu_result_in(alu_result_in), .rs2_value_in(rs2_value_in),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_wstrb_out(mem_wstrb_out),
    .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in),
    .done_out(done_out), .wb_en_out(wb_en_out), .wb_rd_out(wb_rd_out),
    .wb_data_out(wb_data_out), .fault_out(fault_out), .misalign_out(misalign_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] d);
    opcode_in = op; funct3_in = f3; rd_in = rd; alu_result_in = a; rs2_value_in = d;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rdata);
    mem_rdata_in = rdata; mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++;
    if ({ready_out, mem_req_out, done_out, wb_en_out, fault_out, misalign_out} !== 6'b100000) begin
      bad++; $display("FAIL reset_flags got=%b exp=100000", {ready_out, mem_req_out, done_out, wb_en_out, fault_out, misalign_out});
    end
    total++;
    if ({mem_addr_out, wb_data_out, wb_rd_out, mem_wstrb_out} !== 73'b0) begin
      bad++; $display("FAIL reset_regs addr=%h wb=%h rd=%0d strb=%b exp all zero", mem_addr_out, wb_data_out, wb_rd_out, mem_wstrb_out);
    end
    reset_in = 1'b0;
  endtask

  task automatic test_alu();
    issue(7'b0110011, 3'b000, 5'd5, 32'h0000_002A, 32'h0);
    total++;
    if ({done_out, wb_en_out, fault_out, mem_req_out, ready_out} !== 5'b11000) begin
      bad++; $display("FAIL alu_flags got=%b exp=11000", {done_out, wb_en_out, fault_out, mem_req_out, ready_out});
    end
    total++;
    if (wb_rd_out !== 5'd5 || wb_data_out !== 32'h2A) begin
      bad++; $display("FAIL alu_wb rd=%0d data=%h exp rd=5 data=0000002a", wb_rd_out, wb_data_out);
    end
    tick();
    total++;
    if ({done_out, wb_en_out, ready_out} !== 3'b001 || wb_data_out !== 32'h2A) begin
      bad++; $display("FAIL alu_after got=%b data=%h exp=001 data=0000002a", {done_out, wb_en_out, ready_out}, wb_data_out);
    end
    issue(7'b1101111, 3'b000, 5'd6, 32'h0000_0099, 32'h0);
    total++;
    if ({done_out, wb_en_out, fault_out, mem_req_out} !== 4'b1000 || wb_data_out !== 32'h2A) begin
      bad++; $display("FAIL other_op got=%b data=%h exp=1000 data=0000002a", {done_out, wb_en_out, fault_out, mem_req_out}, wb_data_out);
    end
    tick();
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
    issue(7'b0000011, f3, 5'd7, a, 32'h0);
    total++;
    if ({mem_req_out, mem_we_out, mem_wstrb_out} !== 6'b100000 || mem_addr_out !== exp_addr) begin
      bad++; $display("FAIL load_req f3=%b got=%b addr=%h exp=100000 addr=%h", f3, {mem_req_out, mem_we_out, mem_wstrb_out}, mem_addr_out, exp_addr);
    end
    tick();
    tick();
    total++;
    if (mem_req_out !== 1'b1 || done_out !== 1'b0 || mem_addr_out !== exp_addr) begin
      bad++; $display("FAIL load_hold f3=%b req=%b done=%b addr=%h exp req=1 done=0 addr=%h", f3, mem_req_out, done_out, mem_addr_out, exp_addr);
    end
    ack(rdata);
    total++;
    if ({done_out, wb_en_out, fault_out, mem_req_out} !== 4'b1100 || wb_data_out !== exp_data || wb_rd_out !== 5'd7) begin
      bad++; $display("FAIL load_done f3=%b got=%b data=%h rd=%0d exp=1100 data=%h rd=7", f3, {done_out, wb_en_out, fault_out, mem_req_out}, wb_data_out, wb_rd_out, exp_data);
    end
    tick();
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
    issue(7'b0100011, f3, 5'd0, a, d);
    total++;
    if ({mem_req_out, mem_we_out, mem_wstrb_out} !== {2'b11, exp_strb} || mem_wdata_out !== exp_wdata || mem_addr_out !== exp_addr) begin
      bad++; $display("FAIL store_req f3=%b got=%b wdata=%h addr=%h exp=%b wdata=%h addr=%h", f3, {mem_req_out, mem_we_out, mem_wstrb_out}, mem_wdata_out, mem_addr_out, {2'b11, exp_strb}, exp_wdata, exp_addr);
    end
    ack(32'hFFFF_FFFF);
    total++;
    if ({done_out, wb_en_out, fault_out, mem_req_out} !== 4'b1000) begin
      bad++; $display("FAIL store_done f3=%b got=%b exp=1000", f3, {done_out, wb_en_out, fault_out, mem_req_out});
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [31:0] prev;
    prev = wb_data_out;
    issue(7'b0000011, 3'b010, 5'd9, 32'h0000_4000, 32'h0);
    repeat (3) tick();
    total++;
    if (mem_req_out !== 1'b1 || done_out !== 1'b0) begin
      bad++; $display("FAIL timeout_early req=%b done=%b exp req=1 done=0", mem_req_out, done_out);
    end
    tick();
    total++;
    if ({done_out, wb_en_out, fault_out, mem_req_out} !== 4'b1010) begin
      bad++; $display("FAIL timeout_abort got=%b exp=1010", {done_out, wb_en_out, fault_out, mem_req_out});
    end
    tick();
    ack(32'h1234_5678);
    total++;
    if ({ready_out, done_out, mem_req_out, fault_out} !== 4'b1000 || wb_data_out !== prev) begin
      bad++; $display("FAIL stray_ack got=%b data=%h exp=1000 data=%h", {ready_out, done_out, mem_req_out, fault_out}, wb_data_out, prev);
    end
  endtask

  task automatic test_misalign();
    issue(7'b0000011, 3'b010, 5'd3, 32'h0000_3001, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if ({done_out, wb_en_out, fault_out, misalign_out, mem_req_out} !== 5'b10010) begin
      bad++; $display("FAIL misalign_trap got=%b exp=10010", {done_out, wb_en_out, fault_out, misalign_out, mem_req_out});
    end
    tick();
`else
    total++;
    if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h0000_3000) begin
      bad++; $display("FAIL misalign_req req=%b addr=%h exp req=1 addr=00003000", mem_req_out, mem_addr_out);
    end
    ack(32'hDEAD_BEEF);
    total++;
    if ({done_out, wb_en_out, misalign_out} !== 3'b110 || wb_data_out !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL misalign_load got=%b data=%h exp=110 data=deadbeef", {done_out, wb_en_out, misalign_out}, wb_data_out);
    end
    tick();
`endif
  endtask

  task automatic test_illegal();
    issue(7'b0000011, 3'b011, 5'd4, 32'h0000_1000, 32'h0);
    total++;
    if ({done_out, wb_en_out, fault_out, mem_req_out} !== 4'b1010) begin
      bad++; $display("FAIL illegal_load got=%b exp=1010", {done_out, wb_en_out, fault_out, mem_req_out});
    end
    tick();
    issue(7'b0100011, 3'b100, 5'd4, 32'h0000_1000, 32'h0);
    total++;
    if ({done_out, wb_en_out, fault_out, mem_req_out} !== 4'b1010) begin
      bad++; $display("FAIL illegal_store got=%b exp=1010", {done_out, wb_en_out, fault_out, mem_req_out});
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    issue(7'b0000011, 3'b010, 5'd8, 32'h0000_6000, 32'h0);
    total++;
    if (mem_req_out !== 1'b1) begin
      bad++; $display("FAIL midreset_pre req=%b exp=1", mem_req_out);
    end
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    total++;
    if ({mem_req_out, ready_out, done_out} !== 3'b010 || mem_addr_out !== 32'h0 || wb_data_out !== 32'h0) begin
      bad++; $display("FAIL midreset got=%b addr=%h wb=%h exp=010 addr=0 wb=0", {mem_req_out, ready_out, done_out}, mem_addr_out, wb_data_out);
    end
  endtask

  task automatic test_back_to_back();
    opcode_in = 7'b0010011; funct3_in = 3'b000; rd_in = 5'd1; alu_result_in = 32'h11;
    valid_in = 1'b1;
    tick();
    total++;
    if (done_out !== 1'b1 || wb_data_out !== 32'h11 || ready_out !== 1'b0) begin
      bad++; $display("FAIL b2b_first done=%b data=%h ready=%b exp done=1 data=00000011 ready=0", done_out, wb_data_out, ready_out);
    end
    rd_in = 5'd2; alu_result_in = 32'h22;
    tick();
    total++;
    if (done_out !== 1'b0 || wb_data_out !== 32'h11) begin
      bad++; $display("FAIL b2b_gap done=%b data=%h exp done=0 data=00000011", done_out, wb_data_out);
    end
    tick();
    valid_in = 1'b0;
    total++;
    if (done_out !== 1'b1 || wb_data_out !== 32'h22 || wb_rd_out !== 5'd2) begin
      bad++; $display("FAIL b2b_second done=%b data=%h rd=%0d exp done=1 data=00000022 rd=2", done_out, wb_data_out, wb_rd_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load(3'b000, 32'h0000_1003, 32'h80FF_0000, 32'h0000_1000, 32'hFFFF_FF80);
    test_load(3'b100, 32'h0000_1003, 32'h80FF_0000, 32'h0000_1000, 32'h0000_0080);
    test_load(3'b001, 32'h0000_1002, 32'h80FF_0000, 32'h0000_1000, 32'hFFFF_80FF);
    test_load(3'b101, 32'h0000_1002, 32'h80FF_0000, 32'h0000_1000, 32'h0000_80FF);
    test_load(3'b000, 32'h0000_1001, 32'h1234_7F00, 32'h0000_1000, 32'h0000_007F);
    test_store(3'b001, 32'h0000_2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h0000_2000);
    test_store(3'b000, 32'h0000_5001, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 32'h0000_5000);
    test_store(3'b010, 32'h0000_5004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0000_5004);
    test_timeout();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU. It takes the ALU result as the effective address, or as a pass-through value for non-memory ops.
- Runs the data-memory request/ack handshake and generates byte strobes for stores.
- Aligns and sign/zero-extends load data.
- Presents one registered writeback beat per accepted instruction.

Parameters:
- ACK_TIMEOUT, default 16: max cycles in ACCESS without mem_ack_in before abort; 0 disables the timeout.
- CNT_W, default 8: width of the timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- reset_in  input  1  synchronous active-high reset
- valid_in  input  1  upstream instruction valid; held until accepted
- ready_out  output  1  high only in IDLE; accept = valid_in & ready_out
- opcode_in  input  7  RV32I opcode
- funct3_in  input  3  access size/sign
- rd_in  input  5  destination register
- alu_result_in  input  32  effective address, or result for ALU ops
- rs2_value_in  input  32  store data
- mem_req_out  output  1  memory request, registered
- mem_we_out  output  1  1 = store
- mem_addr_out  output  32  word address (bits [1:0] = 0)
- mem_wdata_out  output  32  lane-replicated store data
- mem_wstrb_out  output  4  byte enables; 0000 for loads
- mem_rdata_in  input  32  read word, valid with mem_ack_in
- mem_ack_in  input  1  one-cycle completion pulse
- done_out  output  1  one-cycle writeback beat
- wb_en_out  output  1  register write enable, qualified by done_out
- wb_rd_out  output  5  destination register
- wb_data_out  output  32  writeback data
- fault_out  output  1  illegal funct3 or timeout, with done_out
- misalign_out  output  1  misaligned access, with done_out

Behaviour:
- States: IDLE, ACCESS, DONE. Reset forces IDLE and zeroes every output and the counter on the next edge, including when reset arrives mid-ACCESS. A late mem_ack_in arriving in IDLE is ignored.
- Opcodes: load = 0000011, store = 0100011, reg_reg = 0110011, immediate = 0010011.
- IDLE + accept, ALU op (reg_reg/immediate):
  - Next state DONE; wb_data = alu_result_in; wb_en = 1. Latency is 1 cycle.
  - Any other non-memory opcode: DONE with wb_en = 0.
- IDLE + accept, load/store with illegal funct3:
  - Loads: legal funct3 are 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: legal funct3 are 000 SB, 001 SH, 010 SW.
  - Illegal: no memory request; DONE with wb_en = 0 and fault_out = 1.
- IDLE + accept, legal load/store:
  - All mem_* outputs are registered; next state ACCESS; counter cleared.
  - mem_addr_out = {addr[31:2], 2'b00}.
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: wstrb = 0011 << {addr[1], 1'b0}; wdata = halfword replicated x2.
  - SW: wstrb = 1111.
- ACCESS:
  - mem_req_out and all mem_* outputs stay stable until ack.
  - On mem_ack_in: mem_req_out drops at the next edge and the next state is DONE.
  - Load: the lane selected by addr[1:0] (byte) or addr[1] (half) is sign-extended (LB/LH) or zero-extended (LBU/LHU); wb_en = 1.
  - Store: wb_en = 0.
- Timeout (ACK_TIMEOUT > 0): the counter increments each ACCESS cycle without ack. When the count reaches ACK_TIMEOUT: abort, drop mem_req_out, go to DONE with fault_out = 1 and wb_en = 0. Ack takes priority if it arrives on the same cycle as expiry.
- DONE: done_out = 1 for exactly one cycle with wb_* and flags valid; then IDLE. ready_out is low in DONE.
- Outside DONE: done_out, wb_en_out, fault_out and misalign_out are 0; wb_data_out and wb_rd_out hold their last values.
- Misaligned access: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0. Handling depends on the macro below.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no memory request. The unit goes IDLE -> DONE with misalign_out = 1 and wb_en = 0.
- Undefined: the misaligned address bits are treated as zero (half: addr[0] = 0; word: addr[1:0] = 0) and the access proceeds normally. misalign_out is tied to 0.

Test Plan:
- ALU op: opcode 0110011, alu_result = 0x0000_002A, rd = 5 -> done_out one cycle after accept; wb_en = 1; wb_rd = 5; wb_data = 0x2A; no mem_req.
- LB at addr 0x1003: mem_rdata = 0x80FF_0000, ack after 3 cycles -> mem_addr = 0x1000, wstrb = 0000; wb_data = 0xFFFF_FF80. Repeat as LBU -> wb_data = 0x0000_0080.
- SH at addr 0x2002: rs2 = 0x1234_ABCD -> wstrb = 1100; wdata = 0xABCD_ABCD; we = 1; done with wb_en = 0.
- Timeout with ACK_TIMEOUT = 4 and no ack -> mem_req drops after 4 ACCESS cycles; done_out with fault_out = 1. A later stray ack is ignored and the unit stays IDLE.
- LW at addr 0x3001 -> with macro defined: no mem_req, misalign_out = 1. Without the macro: mem_addr = 0x3000, normal load.
- reset_in asserted during ACCESS -> next edge: mem_req = 0, ready_out = 1, done_out = 0. funct3 = 011 load -> fault_out = 1, no request.
